// File: rtl/key_despeckle_comp.sv
// Key despeckle and composite stage: 3-tap horizontal majority filter on the keyer
// flag, fill-colour substitution for keyed pixels, and a per-frame keyed-pixel counter.
module key_despeckle_comp #(
  parameter logic [7:0]  FILL_R    = 8'd0,
  parameter logic [7:0]  FILL_G    = 8'd0,
  parameter logic [7:0]  FILL_B    = 8'd0,
  parameter bit          DESPECKLE = 1'b1,
  parameter int unsigned CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       r,
  input  logic [7:0]       g,
  input  logic [7:0]       b,
  input  logic             key_in,
  input  logic             line_start,
  input  logic             frame_start,
  input  logic [23:0]      pass_in,
  output logic [7:0]       outR,
  output logic [7:0]       outG,
  output logic [7:0]       outB,
  output logic             key_out,
  output logic [23:0]      pass_thru,
  output logic [CNT_W-1:0] key_count,
  output logic             count_strobe
);

  typedef struct packed {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        key;
    logic        ls;
    logic        fs;
    logic [23:0] pass;
  } pix_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pix_t             in_c;
  pix_t             s1;
  logic             k_prev;
  logic             l_c;
  logic             r_c;
  logic             maj_c;
  logic             kf_c;
  logic             keyed_c;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc_c;

  // Bundle the incoming pixel so it travels through the pipe as one word.
  always_comb begin
    in_c      = '0;
    in_c.r    = r;
    in_c.g    = g;
    in_c.b    = b;
    in_c.key  = key_in;
    in_c.ls   = line_start;
    in_c.fs   = frame_start;
    in_c.pass = pass_in;
  end

  // s1 holds the centre pixel; the live input is its right neighbour and
  // k_prev its left neighbour. Line edges replicate the centre key.
  always_comb begin
    l_c       = s1.ls ? s1.key : k_prev;
    r_c       = line_start ? s1.key : key_in;
    maj_c     = (l_c & s1.key) | (l_c & r_c) | (s1.key & r_c);
    kf_c      = DESPECKLE ? maj_c : s1.key;
    keyed_c   = en & kf_c;
    cnt_inc_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(keyed_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      k_prev <= 1'b0;
    end else begin
      s1     <= in_c;
      k_prev <= s1.key;
    end
  end

  // Output stage; en is sampled in the clock that loads the emitted pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outR         <= '0;
      outG         <= '0;
      outB         <= '0;
      key_out      <= 1'b0;
      pass_thru    <= '0;
      key_count    <= '0;
      count_strobe <= 1'b0;
      cnt          <= '0;
    end else begin
      outR      <= keyed_c ? FILL_R : s1.r;
      outG      <= keyed_c ? FILL_G : s1.g;
      outB      <= keyed_c ? FILL_B : s1.b;
      key_out   <= kf_c;
      pass_thru <= s1.pass;
      if (s1.fs) begin
        key_count    <= cnt;
        count_strobe <= 1'b1;
        cnt          <= CNT_W'(keyed_c);
      end else begin
        count_strobe <= 1'b0;
        cnt          <= cnt_inc_c;
      end
    end
  end

endmodule

// File: tb/tb_key_despeckle_comp.sv
// Bench for key_despeckle_comp: two parameterisations driven with the same stream,
// checked every cycle against a window-based model plus literal pins.
module tb_key_despeckle_comp;

  localparam int unsigned MAXN  = 512;
  localparam logic [23:0] FILL1 = 24'h123456;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        key_in = 1'b0;
  logic        line_start = 1'b0;
  logic        frame_start = 1'b0;
  logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
  logic [23:0] pass_in = 24'd0;

  logic [7:0]  outR0, outG0, outB0, outR1, outG1, outB1;
  logic        key_out0, key_out1, stb0, stb1;
  logic [23:0] pass0, pass1;
  logic [19:0] kc0;
  logic [3:0]  kc1;

  always #5 clk = ~clk;

  key_despeckle_comp dut0 (
    .clk(clk), .rst(rst), .en(en), .r(r), .g(g), .b(b), .key_in(key_in),
    .line_start(line_start), .frame_start(frame_start), .pass_in(pass_in),
    .outR(outR0), .outG(outG0), .outB(outB0), .key_out(key_out0),
    .pass_thru(pass0), .key_count(kc0), .count_strobe(stb0));

  key_despeckle_comp #(.FILL_R(8'h12), .FILL_G(8'h34), .FILL_B(8'h56),
                       .DESPECKLE(1'b0), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .r(r), .g(g), .b(b), .key_in(key_in),
    .line_start(line_start), .frame_start(frame_start), .pass_in(pass_in),
    .outR(outR1), .outG(outG1), .outB(outB1), .key_out(key_out1),
    .pass_thru(pass1), .key_count(kc1), .count_strobe(stb1));

  bit          st_key[MAXN], st_ls[MAXN], st_fs[MAXN], st_en[MAXN];
  logic [23:0] st_rgb[MAXN], st_pass[MAXN];
  logic        cap_key[MAXN], cap_stb[MAXN];
  logic [23:0] cap_rgb[MAXN], cap_pass[MAXN];
  logic [19:0] cap_kc[MAXN];
  logic [3:0]  cap1_kc[MAXN];

  int tests = 0;
  int fails = 0;
  int m_cnt[2];
  int m_kc[2];

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, t, act, exp);
    end
  endtask

  // Pixels before the stream start (negative index) are the flushed zero pixel.
  function automatic bit getk(input int p);  return (p < 0) ? 1'b0 : st_key[p]; endfunction
  function automatic bit getls(input int p); return (p < 0) ? 1'b0 : st_ls[p];  endfunction
  function automatic bit getfs(input int p); return (p < 0) ? 1'b0 : st_fs[p];  endfunction
  function automatic bit gete(input int p);  return (p < 0) ? 1'b0 : st_en[p];  endfunction
  function automatic logic [23:0] getrgb(input int p);  return (p < 0) ? 24'd0 : st_rgb[p];  endfunction
  function automatic logic [23:0] getpass(input int p); return (p < 0) ? 24'd0 : st_pass[p]; endfunction

  function automatic bit kf_of(input int p, input bit desp);
    bit c, lk, rk;
    int ones;
    c  = getk(p);
    lk = getls(p) ? c : getk(p - 1);
    rk = getls(p + 1) ? c : getk(p + 1);
    ones = int'(lk) + int'(c) + int'(rk);
    return desp ? (ones >= 2) : c;
  endfunction

  // Outputs seen in cycle t belong to pixel t-2.
  task automatic check_cycle(input int t);
    int p = t - 2;
    bit kf, keyed, exp_stb, desp;
    int maxc;
    logic [23:0] exp_rgb, a_rgb, a_pass;
    logic a_key, a_stb;
    logic [31:0] a_kc;
    for (int d = 0; d < 2; d++) begin
      desp  = (d == 0);
      maxc  = (d == 0) ? 1048575 : 15;
      kf    = kf_of(p, desp);
      keyed = gete(p + 1) & kf;
      exp_rgb = keyed ? ((d == 0) ? 24'h000000 : FILL1) : getrgb(p);
      if (getfs(p)) begin
        exp_stb  = 1'b1;
        m_kc[d]  = m_cnt[d];
        m_cnt[d] = int'(keyed);
      end else begin
        exp_stb = 1'b0;
        if (m_cnt[d] < maxc) m_cnt[d] += int'(keyed);
      end
      if (d == 0) begin
        a_rgb = {outR0, outG0, outB0}; a_pass = pass0; a_key = key_out0;
        a_stb = stb0; a_kc = 32'(kc0);
      end else begin
        a_rgb = {outR1, outG1, outB1}; a_pass = pass1; a_key = key_out1;
        a_stb = stb1; a_kc = 32'(kc1);
      end
      chk($sformatf("d%0d_rgb", d), t, 32'(a_rgb), 32'(exp_rgb));
      chk($sformatf("d%0d_key_out", d), t, 32'(a_key), 32'(kf));
      chk($sformatf("d%0d_pass_thru", d), t, 32'(a_pass), 32'(getpass(p)));
      chk($sformatf("d%0d_key_count", d), t, a_kc, 32'(m_kc[d]));
      chk($sformatf("d%0d_count_strobe", d), t, 32'(a_stb), 32'(exp_stb));
    end
    cap_key[t] = key_out0; cap_stb[t] = stb0; cap_rgb[t] = {outR0, outG0, outB0};
    cap_pass[t] = pass0;   cap_kc[t] = kc0;   cap1_kc[t] = kc1;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < int'(MAXN); i++) begin
      st_key[i] = 1'b0; st_ls[i] = 1'b0; st_fs[i] = 1'b0; st_en[i] = 1'b1;
      st_rgb[i] = 24'(i * 40503 + 7); st_pass[i] = 24'(i * 977 + 3);
    end
  endtask

  task automatic check_reset_zero(input int t);
    chk("rst_rgb0", t, 32'({outR0, outG0, outB0}), 32'd0);
    chk("rst_rgb1", t, 32'({outR1, outG1, outB1}), 32'd0);
    chk("rst_key", t, 32'({key_out0, key_out1}), 32'd0);
    chk("rst_pass", t, 32'(pass0 | pass1), 32'd0);
    chk("rst_count", t, 32'({kc0, kc1}), 32'd0);
    chk("rst_strobe", t, 32'({stb0, stb1}), 32'd0);
  endtask

  // Release reset, stream n pixels, then assert reset mid-stream.
  task automatic run_seg(input int n);
    for (int d = 0; d < 2; d++) begin m_cnt[d] = 0; m_kc[d] = 0; end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < n; t++) begin
      key_in = st_key[t]; line_start = st_ls[t]; frame_start = st_fs[t];
      en = st_en[t]; {r, g, b} = st_rgb[t]; pass_in = st_pass[t];
      @(negedge clk);
      check_cycle(t);
      if (t < n - 1) begin @(posedge clk); #1; end
    end
    #2 rst = 1'b1;
    #1 check_reset_zero(n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nstb;
    // Directed line/edge/bypass stream.
    clear_stim();
    st_fs[0] = 1'b1;
    st_ls[0] = 1'b1; st_ls[3] = 1'b1; st_ls[17] = 1'b1; st_ls[18] = 1'b1;
    st_key[0] = 1'b1; st_key[6] = 1'b1;
    for (int i = 10; i <= 16; i++) st_key[i] = (i != 13);
    for (int i = 18; i <= 21; i++) st_key[i] = 1'b1;
    for (int i = 19; i <= 22; i++) st_en[i] = 1'b0;
    st_rgb[6] = 24'h112233;
    for (int i = 19; i <= 21; i++) st_rgb[i] = {8'd10, 8'd200, 8'd30};
    st_pass[20] = 24'hABCDEF;
    run_seg(26);
    chk("edge_first_key", 2, 32'(cap_key[2]), 32'd1);
    chk("edge_second_key", 3, 32'(cap_key[3]), 32'd0);
    for (int t = 6; t <= 10; t++) chk("speckle_removed", t, 32'(cap_key[t]), 32'd0);
    chk("speckle_rgb", 8, 32'(cap_rgb[8]), 32'h112233);
    for (int t = 13; t <= 17; t++) begin
      chk("hole_filled_key", t, 32'(cap_key[t]), 32'd1);
      chk("hole_filled_rgb", t, 32'(cap_rgb[t]), 32'd0);
    end
    chk("one_px_line_key", 19, 32'(cap_key[19]), 32'd0);
    chk("bypass_rgb", 22, 32'(cap_rgb[22]), 32'h0AC81E);
    chk("bypass_pass", 22, 32'(cap_pass[22]), 32'hABCDEF);
    chk("bypass_key", 22, 32'(cap_key[22]), 32'd1);

    // 100-pixel frame with 37 keyed pixels, then the next frame_start.
    clear_stim();
    st_fs[0] = 1'b1; st_ls[0] = 1'b1; st_fs[100] = 1'b1; st_ls[100] = 1'b1;
    for (int i = 0; i < 37; i++) st_key[i] = 1'b1;
    run_seg(106);
    chk("frame_count", 102, 32'(cap_kc[102]), 32'd37);
    chk("frame_count_sat4", 102, 32'(cap1_kc[102]), 32'd15);
    nstb = 0;
    for (int t = 3; t < 106; t++) nstb += int'(cap_stb[t]);
    chk("single_strobe", 102, 32'(nstb), 32'd1);

    // Randomised streams.
    for (int s = 0; s < 3; s++) begin
      clear_stim();
      for (int i = 0; i < 400; i++) begin
        st_key[i]  = (s == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
        st_ls[i]   = ($urandom_range(0, 7) == 0);
        st_fs[i]   = ($urandom_range(0, 39) == 0);
        st_en[i]   = ($urandom_range(0, 7) != 0);
        st_rgb[i]  = 24'($urandom);
        st_pass[i] = 24'($urandom);
      end
      run_seg(400);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
